// File: rtl/trackball_pkg.sv
// Shared definitions for the trackball quadrature-step emulator.
//   - Default timing/width parameters used by trackball_emulator and trackball_axis.
//   - Axis FSM state encoding.
//   - max_int: constant helper for sizing the shared phase counter.
package trackball_pkg;

   localparam int HALF_PERIOD_DEF = 1024;
   localparam int SETUP_DEF       = 16;
   localparam int ACC_W_DEF       = 12;
   localparam int DELTA_W         = 9;

   typedef enum logic [1:0] {
      AX_IDLE,
      AX_SETUP,
      AX_HIGH,
      AX_LOW
   } axis_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/trackball_axis.sv
// One axis of the trackball emulator: signed motion accumulator plus the
// step sequencer that turns it into dir/clock quadrature steps.
// Ports:
//   clk, rst_l      system clock, async active-low reset
//   enable          allows a new step to start from IDLE
//   accept          delta is taken this edge (already qualified by ready)
//   delta           signed motion delta, DELTA_W bits
//   room            accumulator can absorb any delta without overflow
//   busy_nxt        next-cycle busy term (axis active or acc nonzero)
//   step_dir        latched step direction, 1 = positive
//   step_clk        step clock
//
// state    | meaning
// ---------+------------------------------------------------------------
// AX_IDLE  | no step; start when enabled and acc != 0, latching dir
// AX_SETUP | dir stable, step clock low, SETUP cycles
// AX_HIGH  | step clock high for HALF_PERIOD cycles; unit consumed on entry
// AX_LOW   | step clock low for HALF_PERIOD cycles, then back to IDLE
module trackball_axis
   import trackball_pkg::*;
#(
   parameter int HALF_PERIOD = HALF_PERIOD_DEF,
   parameter int SETUP       = SETUP_DEF,
   parameter int ACC_W       = ACC_W_DEF
) (
   input  logic               clk,
   input  logic               rst_l,
   input  logic               enable,
   input  logic               accept,
   input  logic [DELTA_W-1:0] delta,
   output logic               room,
   output logic               busy_nxt,
   output logic               step_dir,
   output logic               step_clk
);

   localparam int CNT_W = $clog2(max_int(HALF_PERIOD, SETUP)) + 1;
   // Largest |acc| that still leaves headroom for a full-scale delta.
   localparam logic signed [ACC_W-1:0] ROOM_LIM =
      ACC_W'((1 << (ACC_W-1)) - 1 - (1 << (DELTA_W-1)));

   axis_state_t             state;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nxt;
   logic signed [ACC_W-1:0] delta_ext;
   logic signed [ACC_W-1:0] step;
   logic                    cnt_zero;
   logic                    start;
   logic                    active_nxt;

   assign cnt_zero = (cnt == '0);
   assign start    = (state == AX_IDLE) && enable && (acc != '0);
   assign room     = (acc <= ROOM_LIM) && (acc >= -ROOM_LIM);
   assign busy_nxt = active_nxt || (acc_nxt != '0);

   always_comb begin
      delta_ext = '0;
      if (accept)
         delta_ext = {{(ACC_W-DELTA_W){delta[DELTA_W-1]}}, delta};

      // The unit is consumed on the SETUP->HIGH edge, in the latched direction.
      step = '0;
      if ((state == AX_SETUP) && cnt_zero)
         step = step_dir ? ACC_W'(1) : '1;

      acc_nxt = acc + delta_ext - step;

      active_nxt = 1'b0;
      case (state)
         AX_IDLE:  active_nxt = start;
         AX_SETUP: active_nxt = 1'b1;
         AX_HIGH:  active_nxt = 1'b1;
         AX_LOW:   active_nxt = !cnt_zero;
         default:  active_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state    <= AX_IDLE;
         cnt      <= '0;
         acc      <= '0;
         step_dir <= 1'b0;
         step_clk <= 1'b0;
      end else begin
         acc <= acc_nxt;
         case (state)
            AX_IDLE: begin
               if (start) begin
                  state    <= AX_SETUP;
                  cnt      <= CNT_W'(SETUP - 1);
                  step_dir <= !acc[ACC_W-1];
               end
            end
            AX_SETUP: begin
               if (cnt_zero) begin
                  state    <= AX_HIGH;
                  cnt      <= CNT_W'(HALF_PERIOD - 1);
                  step_clk <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            AX_HIGH: begin
               if (cnt_zero) begin
                  state    <= AX_LOW;
                  cnt      <= CNT_W'(HALF_PERIOD - 1);
                  step_clk <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            AX_LOW: begin
               if (cnt_zero)
                  state <= AX_IDLE;
               else
                  cnt <= cnt - CNT_W'(1);
            end
            default: begin
               state    <= AX_IDLE;
               step_clk <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/trackball_emulator.sv
// Trackball emulator: accepts signed X/Y motion deltas and replays them as
// dir/clock step pairs on two independent axes.
// Ports:
//   clk, rst_l            system clock, async active-low reset
//   enable                allows new steps to start
//   move_valid/ready      delta handshake; ready depends on registered acc only
//   move_dx, move_dy      signed 9-bit deltas
//   hordir1, horclk1      horizontal direction / step clock
//   verdir1, verclk1      vertical direction / step clock
//   busy                  either axis stepping or holding a nonzero accumulator
module trackball_emulator
   import trackball_pkg::*;
#(
   parameter int HALF_PERIOD = HALF_PERIOD_DEF,
   parameter int SETUP       = SETUP_DEF,
   parameter int ACC_W       = ACC_W_DEF
) (
   input  logic               clk,
   input  logic               rst_l,
   input  logic               enable,
   input  logic               move_valid,
   output logic               move_ready,
   input  logic [DELTA_W-1:0] move_dx,
   input  logic [DELTA_W-1:0] move_dy,
   output logic               hordir1,
   output logic               horclk1,
   output logic               verdir1,
   output logic               verclk1,
   output logic               busy
);

   logic accept;
   logic h_room;
   logic v_room;
   logic h_busy_nxt;
   logic v_busy_nxt;

   // Both axes share one handshake so a delta pair is never split.
   assign move_ready = h_room && v_room;
   assign accept     = move_valid && move_ready;

   trackball_axis #(
      .HALF_PERIOD (HALF_PERIOD),
      .SETUP       (SETUP),
      .ACC_W       (ACC_W)
   ) u_hor (
      .clk      (clk),
      .rst_l    (rst_l),
      .enable   (enable),
      .accept   (accept),
      .delta    (move_dx),
      .room     (h_room),
      .busy_nxt (h_busy_nxt),
      .step_dir (hordir1),
      .step_clk (horclk1)
   );

   trackball_axis #(
      .HALF_PERIOD (HALF_PERIOD),
      .SETUP       (SETUP),
      .ACC_W       (ACC_W)
   ) u_ver (
      .clk      (clk),
      .rst_l    (rst_l),
      .enable   (enable),
      .accept   (accept),
      .delta    (move_dy),
      .room     (v_room),
      .busy_nxt (v_busy_nxt),
      .step_dir (verdir1),
      .step_clk (verclk1)
   );

   // Registered from the axes' next-state terms so busy tracks the axes
   // without a cycle of lag.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)
         busy <= 1'b0;
      else
         busy <= h_busy_nxt || v_busy_nxt;
   end

endmodule

// File: tb/tb_trackball_emulator.sv
// Self-checking bench for trackball_emulator (HALF_PERIOD=4, SETUP=2, ACC_W=12).
// A step-timeline model predicts every output each cycle; directed scenarios
// add literal expectations on pulse counts, widths and directions.
module tb_trackball_emulator;

   localparam int HP       = 4;
   localparam int SU       = 2;
   localparam int AW       = 12;
   localparam int LIM      = 1791;
   localparam int STEP_LEN = SU + 2*HP;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       enable = 1'b0;
   logic       move_valid = 1'b0;
   logic [8:0] move_dx = '0;
   logic [8:0] move_dy = '0;
   logic       move_ready;
   logic       hordir1, horclk1, verdir1, verclk1, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   trackball_emulator #(.HALF_PERIOD(HP), .SETUP(SU), .ACC_W(AW)) dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .enable     (enable),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .move_dx    (move_dx),
      .move_dy    (move_dy),
      .hordir1    (hordir1),
      .horclk1    (horclk1),
      .verdir1    (verdir1),
      .verclk1    (verclk1),
      .busy       (busy)
   );

   // ---------------- reference model ----------------
   int m_acc[2];
   bit m_act[2];
   int m_pos[2];
   bit m_dir[2];
   bit m_clk[2];
   bit m_busy;

   function automatic int sx9(input logic [8:0] v);
      if (v[8]) return int'(v) - 512;
      return int'(v);
   endfunction

   function automatic bit m_ready();
      return (m_acc[0] <= LIM) && (m_acc[0] >= -LIM) &&
             (m_acc[1] <= LIM) && (m_acc[1] >= -LIM);
   endfunction

   always @(posedge clk or negedge rst_l) begin
      bit acc_ok;
      int d[2];
      int step;
      if (!rst_l) begin
         for (int a = 0; a < 2; a++) begin
            m_acc[a] = 0; m_act[a] = 0; m_pos[a] = 0; m_dir[a] = 0; m_clk[a] = 0;
         end
         m_busy = 0;
      end else begin
         acc_ok = move_valid && m_ready();
         d[0] = sx9(move_dx);
         d[1] = sx9(move_dy);
         for (int a = 0; a < 2; a++) begin
            step = 0;
            if (!m_act[a]) begin
               if (enable && m_acc[a] != 0) begin
                  m_act[a] = 1; m_pos[a] = 0; m_dir[a] = (m_acc[a] > 0);
               end
            end else begin
               m_pos[a]++;
               if (m_pos[a] == SU) step = m_dir[a] ? 1 : -1;
               if (m_pos[a] == STEP_LEN) m_act[a] = 0;
            end
            m_clk[a] = m_act[a] && (m_pos[a] >= SU) && (m_pos[a] < SU + HP);
            if (acc_ok) m_acc[a] += d[a];
            m_acc[a] -= step;
         end
         m_busy = m_act[0] || m_act[1] || (m_acc[0] != 0) || (m_acc[1] != 0);
      end
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic expect_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("horclk1", horclk1, m_clk[0]);
      chk("hordir1", hordir1, m_dir[0]);
      chk("verclk1", verclk1, m_clk[1]);
      chk("verdir1", verdir1, m_dir[1]);
      chk("busy", busy, m_busy);
      chk("move_ready", move_ready, m_ready());
   end

   // ---------------- pulse monitor ----------------
   int rises[2], net[2], neg_rises[2], first_dir[2];
   int hw_min[2], hw_max[2], per_min[2], per_max[2], dage_min[2];
   int hrun[2], since_rise[2], dage[2];
   int solo_rise;
   logic pclk[2] = '{1'b0, 1'b0};
   logic pdir[2] = '{1'b0, 1'b0};

   task automatic mon_clear();
      for (int a = 0; a < 2; a++) begin
         rises[a] = 0; net[a] = 0; neg_rises[a] = 0; first_dir[a] = -1;
         hw_min[a] = 1000; hw_max[a] = 0; per_min[a] = 1000; per_max[a] = 0;
         dage_min[a] = 1000;
      end
      solo_rise = 0;
   endtask

   always @(negedge clk) begin
      logic c[2];
      logic d[2];
      logic r[2];
      c[0] = horclk1; c[1] = verclk1; d[0] = hordir1; d[1] = verdir1;
      for (int a = 0; a < 2; a++) begin
         r[a] = c[a] && !pclk[a];
         if (d[a] !== pdir[a]) dage[a] = 0; else dage[a]++;
         since_rise[a]++;
         if (r[a]) begin
            if (rises[a] == 0) first_dir[a] = int'(d[a]);
            else begin
               if (since_rise[a] < per_min[a]) per_min[a] = since_rise[a];
               if (since_rise[a] > per_max[a]) per_max[a] = since_rise[a];
            end
            rises[a]++;
            net[a] += d[a] ? 1 : -1;
            if (!d[a]) neg_rises[a]++;
            if (dage[a] < dage_min[a]) dage_min[a] = dage[a];
            since_rise[a] = 0;
            hrun[a] = 0;
         end
         if (c[a]) hrun[a]++;
         if (!c[a] && pclk[a]) begin
            if (hrun[a] < hw_min[a]) hw_min[a] = hrun[a];
            if (hrun[a] > hw_max[a]) hw_max[a] = hrun[a];
         end
         pclk[a] = c[a];
         pdir[a] = d[a];
      end
      if (r[0] != r[1]) solo_rise++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int dx, input int dy);
      move_dx = 9'(dx);
      move_dy = 9'(dy);
      move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      move_dx = '0;
      move_dy = '0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s_timeout: busy got 1 after %0d cycles expected 0", nm, budget);
      end
   endtask

   task automatic wait_hclk(input string nm, input int budget);
      int n;
      n = 0;
      while (!horclk1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!horclk1) begin
         errors++;
         $display("FAIL %s_timeout: horclk1 got 0 expected 1", nm);
      end
   endtask

   task automatic wait_rises(input string nm, input int n_rises, input int budget);
      int n;
      n = 0;
      while (rises[0] < n_rises && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      expect_int({nm, "_rises_reached"}, rises[0], n_rises);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_acc;
      int saw_low;
      int v;
      mon_clear();

      // reset state
      rst_l = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_horclk1", horclk1, 1'b0);
      chk("rst_verclk1", verclk1, 1'b0);
      chk("rst_hordir1", hordir1, 1'b0);
      chk("rst_verdir1", verdir1, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_l = 1'b1;
      @(negedge clk);
      chk("rel_move_ready", move_ready, 1'b1);
      enable = 1'b1;

      // +3 on X only
      mon_clear();
      send(3, 0);
      wait_idle("t1", 200);
      expect_int("t1_h_rises", rises[0], 3);
      expect_int("t1_v_rises", rises[1], 0);
      expect_int("t1_h_net", net[0], 3);
      expect_int("t1_high_min", hw_min[0], 4);
      expect_int("t1_high_max", hw_max[0], 4);
      expect_int("t1_period_min", per_min[0], 11);
      expect_int("t1_period_max", per_max[0], 11);
      expect_int("t1_dir_setup_ok", int'(dage_min[0] >= 2), 1);

      // -2 on X with +2 on Y
      mon_clear();
      send(-2, 2);
      wait_idle("t2", 200);
      expect_int("t2_h_rises", rises[0], 2);
      expect_int("t2_v_rises", rises[1], 2);
      expect_int("t2_h_net", net[0], -2);
      expect_int("t2_v_net", net[1], 2);
      expect_int("t2_unaligned_rises", solo_rise, 0);

      // +2 then -5 while the first step is high: one +1 step, then four -1 steps
      mon_clear();
      send(2, 0);
      wait_hclk("t3", 50);
      send(-5, 0);
      wait_idle("t3", 300);
      expect_int("t3_first_dir", first_dir[0], 1);
      expect_int("t3_h_rises", rises[0], 5);
      expect_int("t3_neg_rises", neg_rises[0], 4);
      expect_int("t3_h_net", net[0], -3);

      // saturating flood of +255
      mon_clear();
      n_acc = 0;
      saw_low = 0;
      move_dx = 9'd255;
      move_dy = '0;
      move_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (move_ready) n_acc++; else saw_low = 1;
         @(negedge clk);
      end
      move_valid = 1'b0;
      move_dx = '0;
      wait_idle("t4", 30000);
      expect_int("t4_accepts", n_acc, 8);
      expect_int("t4_ready_dropped", saw_low, 1);
      expect_int("t4_h_net", net[0], 255 * n_acc);

      // async reset in the middle of a high phase
      mon_clear();
      send(3, 0);
      wait_hclk("t5", 50);
      @(negedge clk);
      #2 rst_l = 1'b0;
      #1;
      chk("t5_async_horclk1", horclk1, 1'b0);
      chk("t5_async_busy", busy, 1'b0);
      chk("t5_async_hordir1", hordir1, 1'b0);
      @(negedge clk);
      rst_l = 1'b1;
      mon_clear();
      repeat (40) @(negedge clk);
      expect_int("t5_no_pulses", rises[0], 0);
      send(1, 0);
      wait_idle("t5b", 100);
      expect_int("t5_new_pulse", rises[0], 1);

      // enable dropped during the second step
      mon_clear();
      send(4, 0);
      wait_rises("t6", 2, 100);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      expect_int("t6_held_rises", rises[0], 2);
      chk("t6_held_busy", busy, 1'b1);
      chk("t6_held_horclk1", horclk1, 1'b0);
      enable = 1'b1;
      wait_idle("t6", 200);
      expect_int("t6_total_rises", rises[0], 4);
      expect_int("t6_h_net", net[0], 4);

      // randomized traffic, occasional async reset
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         enable = ($urandom_range(0, 9) != 0);
         move_valid = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) v = int'($urandom_range(0, 40)) - 20;
         else v = int'($urandom_range(0, 8)) - 4;
         move_dx = 9'(v);
         v = int'($urandom_range(0, 8)) - 4;
         move_dy = 9'(v);
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_l = 1'b0;
            @(negedge clk);
            rst_l = 1'b1;
         end
      end
      @(negedge clk);
      move_valid = 1'b0;
      move_dx = '0;
      move_dy = '0;
      enable = 1'b1;
      wait_idle("drain", 30000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
